// File: rtl/laplace_window_gen_if.sv
// Pixel-in / stencil-out handshake bundle for laplace_window_gen.
// Optional frame flags follow LAPLACE_WIN_FRAME_FLAGS_EN.
interface laplace_window_gen_if #(
  parameter int PIX_W = 8
);
  logic [PIX_W-1:0] in_pix;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] b;
  logic [PIX_W-1:0] d;
  logic [PIX_W-1:0] e;
  logic [PIX_W-1:0] f;
  logic [PIX_W-1:0] h;
  logic             out_valid;
  logic             out_ready;
`ifdef LAPLACE_WIN_FRAME_FLAGS_EN
  logic             out_sof;
  logic             out_eof;
`endif

  // master: the window generator itself
  modport master (
    input  in_pix, in_valid, out_ready,
    output in_ready, b, d, e, f, h, out_valid
`ifdef LAPLACE_WIN_FRAME_FLAGS_EN
    , output out_sof, output out_eof
`endif
  );

  // slave: pixel source plus window consumer
  modport slave (
    output in_pix, in_valid, out_ready,
    input  in_ready, b, d, e, f, h, out_valid
`ifdef LAPLACE_WIN_FRAME_FLAGS_EN
    , input out_sof, input out_eof
`endif
  );
endinterface

// File: rtl/laplace_window_gen.sv
// Raster pixel stream -> 5-point cross stencil, one window per interior pixel, 1-cycle latency,
// single output register stalls input while held. Optional flags: LAPLACE_WIN_FRAME_FLAGS_EN.
module laplace_window_gen #(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int PIX_W = 8
) (
  input  logic clk,
  input  logic rst,
  laplace_window_gen_if.master io
);
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [XW-1:0] X_PEN  = XW'(IMG_W - 2);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  logic [PIX_W-1:0] lb1_q [IMG_W];   // row y-1
  logic [PIX_W-1:0] lb2_q [IMG_W];   // row y-2
  logic [PIX_W-1:0] prev1_q;         // row y-1 at x-1, lb1 slot already overwritten
  logic [XW-1:0]    x_q, x_d, xp1;
  logic [YW-1:0]    y_q, y_d;
  logic [PIX_W-1:0] b_q, d_q, e_q, f_q, h_q;
  logic             out_valid_q;
  logic             in_xfer, win;

  assign io.in_ready = !out_valid_q || io.out_ready;
  assign in_xfer     = io.in_valid && io.in_ready;
  assign win         = (y_q >= Y_TWO) && (x_q != '0) && (x_q != X_LAST);
  assign xp1         = (x_q == X_LAST) ? '0 : x_q + X_ONE;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (in_xfer) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + X_ONE;
      end
    end
  end

  // Buffer contents need no reset: rows 0-1 of every frame refill them first.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      lb1_q[x_q] <= io.in_pix;
      lb2_q[x_q] <= lb1_q[x_q];
      prev1_q    <= lb1_q[x_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      b_q         <= '0;
      d_q         <= '0;
      e_q         <= '0;
      f_q         <= '0;
      h_q         <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      if (in_xfer && win) begin
        out_valid_q <= 1'b1;
        b_q         <= lb2_q[x_q];
        d_q         <= prev1_q;
        e_q         <= lb1_q[x_q];
        f_q         <= lb1_q[xp1];
        h_q         <= io.in_pix;
      end else if (io.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.b         = b_q;
  assign io.d         = d_q;
  assign io.e         = e_q;
  assign io.f         = f_q;
  assign io.h         = h_q;

`ifdef LAPLACE_WIN_FRAME_FLAGS_EN
  logic sof_q, eof_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sof_q <= 1'b0;
      eof_q <= 1'b0;
    end else if (in_xfer && win) begin
      sof_q <= (y_q == Y_TWO) && (x_q == X_ONE);
      eof_q <= (y_q == Y_LAST) && (x_q == X_PEN);
    end
  end

  assign io.out_sof = sof_q;
  assign io.out_eof = eof_q;
`endif
endmodule

// File: tb/tb_laplace_window_gen.sv
// Bench for laplace_window_gen on a 5x4 image; scoreboard of stencils from the pixel formula.
module tb_laplace_window_gen;
  localparam int W = 5;
  localparam int H = 4;

  typedef struct packed {
    logic [39:0] taps;
    logic        sof;
    logic        eof;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  laplace_window_gen_if #(.PIX_W(8)) io ();

  laplace_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int win_cnt = 0;
  int first_cyc = -1;
  int xfer11_cyc = -1;
  bit mon_en = 1'b0;
  bit rdy_mode = 1'b0;
  bit prev_stall = 1'b0;
  logic [39:0] prev_taps;
  logic [7:0]  lfsr = 8'hA5;
  exp_t        q[$];
  exp_t        ex;
  logic [39:0] got [16];
  logic [39:0] ref_got [6];
  logic        got_sof [16];
  logic        got_eof [16];
  wire  [39:0] taps_w = {io.b, io.d, io.e, io.f, io.h};
  logic        sof_w, eof_w;

`ifdef LAPLACE_WIN_FRAME_FLAGS_EN
  assign sof_w = io.out_sof;
  assign eof_w = io.out_eof;
`else
  assign sof_w = 1'b0;
  assign eof_w = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    io.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      io.out_ready = rdy_mode ? lfsr[0] : 1'b1;
    end
  end

  // Monitor: handshake rule, stall stability, scoreboard pop
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        total++;
        if (io.in_ready !== !(io.out_valid && !io.out_ready)) begin
          bad++;
          $display("FAIL in_ready: got %b want %b", io.in_ready, !(io.out_valid && !io.out_ready));
        end
        if (prev_stall) begin
          total++;
          if (taps_w !== prev_taps || io.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold: taps %h valid %b, want %h valid 1", taps_w, io.out_valid, prev_taps);
          end
        end
        if (io.out_valid && io.out_ready) begin
          if (win_cnt == 0) first_cyc = cyc;
          if (win_cnt < 16) begin
            got[win_cnt]     = taps_w;
            got_sof[win_cnt] = sof_w;
            got_eof[win_cnt] = eof_w;
          end
          win_cnt++;
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL extra_window: got %h, want none", taps_w);
          end else begin
            ex = q.pop_front();
            if (taps_w !== ex.taps) begin
              bad++;
              $display("FAIL window_taps: got %h want %h", taps_w, ex.taps);
            end
`ifdef LAPLACE_WIN_FRAME_FLAGS_EN
            total++;
            if (sof_w !== ex.sof || eof_w !== ex.eof) begin
              bad++;
              $display("FAIL window_flags: got sof=%b eof=%b want sof=%b eof=%b", sof_w, eof_w, ex.sof, ex.eof);
            end
`endif
          end
        end
        prev_stall = io.out_valid && !io.out_ready;
        prev_taps  = taps_w;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic send(input int base, input int y, input int x, input bit gappy);
    bit   done = 1'b0;
    int   guard = 0;
    exp_t e;
    if (gappy) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        io.in_valid = 1'b0;
      end
    end
    while (!done) begin
      @(negedge clk);
      io.in_valid = 1'b1;
      io.in_pix   = 8'(base + 10 * y + x);
      if (io.in_ready) begin
        done = 1'b1;
        if (y >= 2 && x >= 1 && x <= W - 2) begin
          e.taps = {8'(base + 10 * (y - 2) + x), 8'(base + 10 * (y - 1) + x - 1),
                    8'(base + 10 * (y - 1) + x), 8'(base + 10 * (y - 1) + x + 1),
                    8'(base + 10 * y + x)};
          e.sof  = (y == 2 && x == 1);
          e.eof  = (y == H - 1 && x == W - 2);
          q.push_back(e);
        end
        if (y == 2 && x == 1 && xfer11_cyc < 0) xfer11_cyc = cyc;
      end
      @(posedge clk);
      guard++;
      if (guard > 200) begin
        $display("FAIL send_timeout: in_ready stuck low, want a transfer within 200 cycles");
        $fatal(1);
      end
    end
  endtask

  task automatic drive_frame(input int base, input bit gappy);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        send(base, y, x, gappy);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    io.in_valid = 1'b0;
    while ((q.size() != 0 || io.out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (q.size() != 0 || io.out_valid) begin
      bad++;
      $display("FAIL drain: %0d windows outstanding, want 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    io.in_valid = 1'b0;
    io.in_pix = 8'h00;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1 || taps_w !== 40'h0) begin
      bad++;
      $display("FAIL reset_state: valid=%b ready=%b taps=%h want 0 1 0", io.out_valid, io.in_ready, taps_w);
    end
    total++;
    if (sof_w !== 1'b0 || eof_w !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: sof=%b eof=%b want 0 0", sof_w, eof_w);
    end
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single_frame();
    win_cnt = 0;
    xfer11_cyc = -1;
    first_cyc = -1;
    drive_frame(0, 1'b0);
    drain();
    total++;
    if (win_cnt != 6) begin bad++; $display("FAIL single_count: got %0d want 6", win_cnt); end
    total++;
    if (got[0] !== {8'd1, 8'd10, 8'd11, 8'd12, 8'd21}) begin
      bad++; $display("FAIL single_first: got %h want 010a0b0c15", got[0]);
    end
    total++;
    if (got[5] !== {8'd13, 8'd22, 8'd23, 8'd24, 8'd33}) begin
      bad++; $display("FAIL single_last: got %h want 0d16171821", got[5]);
    end
    total++;
    if (first_cyc != xfer11_cyc + 1) begin
      bad++; $display("FAIL latency: window at cycle %0d want %0d", first_cyc, xfer11_cyc + 1);
    end
    for (int i = 0; i < 6; i++) ref_got[i] = got[i];
  endtask

  task automatic test_backpressure();
    win_cnt = 0;
    rdy_mode = 1'b1;
    drive_frame(0, 1'b1);
    drain();
    rdy_mode = 1'b0;
    total++;
    if (win_cnt != 6) begin bad++; $display("FAIL bp_count: got %0d want 6", win_cnt); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (got[i] !== ref_got[i]) begin
        bad++; $display("FAIL bp_window%0d: got %h want %h", i, got[i], ref_got[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    win_cnt = 0;
    drive_frame(0, 1'b0);
    drive_frame(100, 1'b0);
    drain();
    total++;
    if (win_cnt != 12) begin bad++; $display("FAIL b2b_count: got %0d want 12", win_cnt); end
    total++;
    if (got[6] !== {8'd101, 8'd110, 8'd111, 8'd112, 8'd121}) begin
      bad++; $display("FAIL b2b_window7: got %h want 656e6f7079", got[6]);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 13; i++) send(0, i / W, i % W, 1'b0);
    mon_en = 1'b0;
    @(negedge clk);
    q.delete();
    io.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (io.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", io.out_valid); end
    rst = 1'b0;
    win_cnt = 0;
    mon_en = 1'b1;
    drive_frame(0, 1'b0);
    drain();
    total++;
    if (win_cnt != 6) begin bad++; $display("FAIL midrst_count: got %0d want 6", win_cnt); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (got[i] !== ref_got[i]) begin
        bad++; $display("FAIL midrst_window%0d: got %h want %h", i, got[i], ref_got[i]);
      end
    end
  endtask

`ifdef LAPLACE_WIN_FRAME_FLAGS_EN
  task automatic test_frame_flags();
    int ns = 0;
    int ne = 0;
    win_cnt = 0;
    drive_frame(0, 1'b0);
    drain();
    for (int i = 0; i < 6; i++) begin
      ns += int'(got_sof[i]);
      ne += int'(got_eof[i]);
    end
    total++;
    if (got_sof[0] !== 1'b1 || ns != 1) begin
      bad++; $display("FAIL sof: first=%b count=%0d want 1 1", got_sof[0], ns);
    end
    total++;
    if (got_eof[5] !== 1'b1 || ne != 1) begin
      bad++; $display("FAIL eof: last=%b count=%0d want 1 1", got_eof[5], ne);
    end
  endtask
`endif

  initial begin
    io.in_valid = 1'b0;
    io.in_pix = 8'h00;
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
`ifdef LAPLACE_WIN_FRAME_FLAGS_EN
    test_frame_flags();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench still running at 500us, want finish");
    $fatal(1);
  end
endmodule
